// File: rtl/song_sequencer.sv
// Walks the selected song's note list in the song ROM and hands notes to the
// note player one at a time, reporting end-of-song with a one-cycle pulse.
module song_sequencer #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    play,
    input  logic [1:0]              song,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    input  logic                    note_done,
    output logic [IDX_W+1:0]        rom_addr,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    song_done,
    output logic                    busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PLAYING,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t            state;
    logic [1:0]        song_q;
    logic [IDX_W-1:0]  idx;
    logic [NOTE_W-1:0] rom_note;
    logic [DUR_W-1:0]  rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];
    assign rom_addr = {song_q, idx};
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            song_q    <= '0;
            idx       <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            // A new song selection abandons whatever is in flight, silently.
            if (state != S_IDLE && song != song_q) begin
                state <= S_IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        song_q <= song;
                        if (play) state <= S_FETCH;
                    end
                    S_FETCH: state <= S_WAIT;
                    S_WAIT: begin
                        // Address is held while paused, so the ROM word stays valid.
                        if (play) begin
                            if (rom_dur == '0) begin
                                state     <= S_DONE;
                                song_done <= 1'b1;
                            end else begin
                                note     <= rom_note;
                                duration <= rom_dur;
                                new_note <= 1'b1;
                                state    <= S_PLAYING;
                            end
                        end
                    end
                    S_PLAYING: begin
                        if (note_done) begin
                            if (idx == LAST_IDX) begin
                                state     <= S_DONE;
                                song_done <= 1'b1;
                            end else begin
                                idx   <= idx + 1'b1;
                                state <= S_FETCH;
                            end
                        end
                    end
                    S_DONE: begin
                        idx   <= '0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed vector table, multi-cycle corner cases and
// randomized play/song/note_done traffic against a transaction-level model.
module tb_song_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        play = 1'b0;
    logic        note_done = 1'b0;
    logic [1:0]  song = 2'd0;
    logic [11:0] rom_data;
    logic [6:0]  rom_addr;
    logic        new_note, song_done, busy;
    logic [5:0]  note, duration;

    song_sequencer #(.NOTE_W(6), .DUR_W(6), .IDX_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .play(play), .song(song),
        .rom_data(rom_data), .note_done(note_done), .rom_addr(rom_addr),
        .new_note(new_note), .note(note), .duration(duration),
        .song_done(song_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous song ROM, one cycle of read latency.
    logic [11:0] mem [0:127];
    always @(posedge clk) rom_data <= mem[rom_addr];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: m_lat counts edges until the requested word may be used,
    // -1 while a note is sounding; m_end marks the single end-of-song cycle.
    bit         m_busy, m_end, m_new, m_sdone;
    logic [1:0] m_song;
    logic [4:0] m_idx;
    int         m_lat;
    logic [5:0] m_note, m_dur;

    function automatic logic [31:0] pk(input bit nn, input bit sd, input bit bz,
                                       input logic [5:0] n, input logic [5:0] d,
                                       input logic [6:0] a);
        return {10'd0, nn, sd, bz, n, d, a};
    endfunction

    function automatic logic [31:0] outs();
        return pk(new_note, song_done, busy, note, duration, rom_addr);
    endfunction

    function automatic logic [31:0] model_exp();
        return pk(m_new, m_sdone, m_busy, m_note, m_dur, {m_song, m_idx});
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_end = 1'b0; m_new = 1'b0; m_sdone = 1'b0;
        m_song = 2'd0; m_idx = 5'd0; m_lat = 0; m_note = 6'd0; m_dur = 6'd0;
    endtask

    task automatic model_edge(input bit p, input logic [1:0] s, input bit nd);
        logic [11:0] w;
        m_new = 1'b0;
        m_sdone = 1'b0;
        if (!m_busy) begin
            m_song = s;
            if (p) begin m_busy = 1'b1; m_lat = 2; end
        end else if (s != m_song || m_end) begin
            m_busy = 1'b0; m_end = 1'b0; m_idx = 5'd0;
        end else if (m_lat > 1) begin
            m_lat--;
        end else if (m_lat == 1) begin
            if (p) begin
                w = mem[{m_song, m_idx}];
                if (w[5:0] == 6'd0) begin
                    m_end = 1'b1; m_sdone = 1'b1;
                end else begin
                    m_note = w[11:6]; m_dur = w[5:0]; m_new = 1'b1; m_lat = -1;
                end
            end
        end else if (nd) begin
            if (m_idx == 5'd31) begin m_end = 1'b1; m_sdone = 1'b1; end
            else begin m_idx++; m_lat = 2; end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance an edge, compare everything on the falling edge.
    task automatic step(input bit p, input logic [1:0] s, input bit nd);
        play = p; song = s; note_done = nd;
        @(posedge clk);
        model_edge(p, s, nd);
        @(negedge clk);
        chk("cycle", outs(), model_exp());
    endtask

    typedef struct {
        bit          play;
        logic [1:0]  song;
        bit          nd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 12'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", outs(), 32'd0);
        reset_n = 1'b1;

        // Three-word song 1: two notes then the end marker.
        mem[32] = {6'd5, 6'd3};
        mem[33] = {6'd0, 6'd2};
        mem[34] = {6'd7, 6'd0};
        tbl[0]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 7'd32)};
        tbl[1]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b1, 6'd0, 6'd0, 7'd32)};
        tbl[2]  = '{1'b1, 2'd1, 1'b0, pk(1'b1, 1'b0, 1'b1, 6'd5, 6'd3, 7'd32)};
        tbl[3]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b1, 6'd5, 6'd3, 7'd32)};
        tbl[4]  = '{1'b1, 2'd1, 1'b1, pk(1'b0, 1'b0, 1'b1, 6'd5, 6'd3, 7'd33)};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b1, 6'd5, 6'd3, 7'd33)};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, pk(1'b1, 1'b0, 1'b1, 6'd0, 6'd2, 7'd33)};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, pk(1'b0, 1'b0, 1'b1, 6'd0, 6'd2, 7'd34)};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b1, 6'd0, 6'd2, 7'd34)};
        tbl[9]  = '{1'b1, 2'd1, 1'b0, pk(1'b0, 1'b1, 1'b1, 6'd0, 6'd2, 7'd34)};
        tbl[10] = '{1'b0, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 7'd32)};
        tbl[11] = '{1'b0, 2'd1, 1'b0, pk(1'b0, 1'b0, 1'b0, 6'd0, 6'd2, 7'd32)};

        step(1'b0, 2'd1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].play, tbl[i].song, tbl[i].nd);
            chk($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end

        // Pause while the fetched word is waiting: nothing issues, address holds.
        begin : pause_test
            int pn = 0;
            int moved = 0;
            logic [6:0] a0;
            mem[96] = {6'd9, 6'd4};
            step(1'b0, 2'd3, 1'b0);
            step(1'b1, 2'd3, 1'b0);
            step(1'b1, 2'd3, 1'b0);
            a0 = rom_addr;
            for (int i = 0; i < 10; i++) begin
                step(1'b0, 2'd3, 1'b0);
                if (new_note) pn++;
                if (rom_addr !== a0) moved++;
            end
            chk("pause_no_note", pn, 0);
            chk("pause_addr_held", moved, 0);
            step(1'b1, 2'd3, 1'b0);
            chk("pause_release", {19'd0, new_note, note, duration}, {19'd0, 1'b1, 6'd9, 6'd4});
            step(1'b0, 2'd0, 1'b0);
            step(1'b0, 2'd0, 1'b0);
        end

        // Full 32-note song, note_done four cycles after each new_note.
        begin : full_song
            int nn = 0;
            int sd = 0;
            int since = 0;
            int cyc = 0;
            bit ended = 1'b0;
            for (int w = 0; w < 32; w++)
                mem[64 + w] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
            step(1'b0, 2'd2, 1'b0);
            while (!ended && cyc < 400) begin
                step(1'b1, 2'd2, since == 4);
                if (since == 4) since = 0;
                if (new_note) begin nn++; since = 1; end
                else if (since > 0) since++;
                if (song_done) begin sd++; ended = 1'b1; end
                cyc++;
            end
            chk("full_song_ended", {31'd0, ended}, 32'd1);
            for (int i = 0; i < 5; i++) begin
                step(1'b0, 2'd2, 1'b0);
                if (new_note) nn++;
                if (song_done) sd++;
            end
            chk("full_song_notes", nn, 32);
            chk("full_song_done_pulses", sd, 1);
            chk("full_song_idle", {24'd0, busy, rom_addr}, {24'd0, 1'b0, 7'd64});
        end

        // Song change in the same cycle as note_done at idx 7.
        begin : song_change
            int cyc = 0;
            for (int w = 0; w < 8; w++) mem[32 + w] = {6'(w + 10), 6'd5};
            step(1'b0, 2'd1, 1'b0);
            while (!(m_busy && m_lat == -1 && m_idx == 5'd7) && cyc < 200) begin
                step(1'b1, 2'd1, m_busy && m_lat == -1);
                cyc++;
            end
            chk("chg_reached_idx7", rom_addr, 32'd39);
            step(1'b1, 2'd2, 1'b1);
            chk("chg_to_idle", {24'd0, busy, song_done, new_note, rom_addr[4:0]}, 32'd0);
            step(1'b1, 2'd2, 1'b0);
            chk("chg_refetch", {24'd0, busy, rom_addr}, {24'd0, 1'b1, 7'd64});
            step(1'b0, 2'd3, 1'b0);
            step(1'b0, 2'd3, 1'b0);
        end

        // Asynchronous reset between clock edges while a note is playing.
        begin : async_reset
            int cyc = 0;
            while (!(m_busy && m_lat == -1) && cyc < 20) begin
                step(1'b1, 2'd3, 1'b0);
                cyc++;
            end
            chk("rst_playing", {31'd0, busy}, 32'd1);
            #2 reset_n = 1'b0;
            play = 1'b0;
            #1 chk("rst_immediate", outs(), 32'd0);
            model_reset();
            for (int i = 0; i < 128; i++)
                mem[i] = {6'($urandom_range(0, 63)),
                          ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63))};
            @(posedge clk);
            @(negedge clk);
            chk("rst_held", outs(), 32'd0);
            reset_n = 1'b1;
            for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 1'b0);
            chk("rst_stays_idle", {31'd0, busy}, 32'd0);
        end

        // Randomized traffic against the model.
        begin : random_run
            logic [1:0] s = 2'd3;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 39) == 0) s = 2'($urandom_range(0, 3));
                step($urandom_range(0, 7) != 0, s, $urandom_range(0, 2) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
